load_unit: RTL

LOAD_UNIT -- requirements
Module: load_unit

---
 rtl/load_unit_pkg.sv | 46 ++++
 rtl/load_unit_extract.sv | 30 +++
 rtl/load_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/load_unit_pkg.sv
// Shared types and constants for the RV32I load unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package load_unit_pkg;

    // Load unit control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        WB   = 2'd3
    } state_t;

    // RV32I load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Reported in fault_cause
    typedef enum logic [1:0] {
        CAUSE_ILLEGAL  = 2'd0,
        CAUSE_MISALIGN = 2'd1,
        CAUSE_BUS_ERR  = 2'd2,
        CAUSE_TIMEOUT  = 2'd3
    } fault_cause_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    // True for the five load encodings RV32I defines
    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // Halfwords need even addresses, words need 4-byte alignment
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if ((f3 == F3_LH) || (f3 == F3_LHU)) mis = addr_lo[0];
        else if (f3 == F3_LW)                mis = (addr_lo != 2'b00);
        return mis;
    endfunction

endpackage

// File: rtl/load_unit_extract.sv
// Lane select and sign/zero extension of a memory word for a load.
// Latency: combinational.
// Backpressure: none.
module load_extract
    import load_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane, then extend according to the load type
    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        result   = rdata;
        case (funct3)
            F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  result = {24'd0, byte_sel};
            F3_LH:   result = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  result = {16'd0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// RV32I load unit: checks, issues one memory read, extracts and writes back.
// Latency: 3 cycles accept-to-RegWrite with a zero-wait memory; idle again 1 cycle later.
// Backpressure: one load in flight; req_ready low until the load completes or faults.
module load_unit
    import load_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [4:0]  req_rd,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rerr,
    output logic        RegWrite,
    output logic [4:0]  write_register,
    output logic [31:0] write_data,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_addr
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t       state_q, state_d;
    logic [2:0]   f3_q;
    logic [31:0]  addr_q;
    logic [4:0]   rd_q;
    logic [7:0]   cnt_q;
    logic [31:0]  ext_data;

    logic         accept;
    logic         accept_ok;
    logic         flt_set;
    fault_cause_t flt_cause;
    logic         wb_set;
    logic         timed_out;

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign timed_out = (cnt_q >= TO_LAST);

    load_extract u_extract (
        .funct3  (f3_q),
        .addr_lo (addr_q[1:0]),
        .rdata   (mem_rdata),
        .result  (ext_data)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and per-cycle actions; a response beats a same-cycle timeout
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        accept_ok = 1'b0;
        flt_set   = 1'b0;
        flt_cause = CAUSE_ILLEGAL;
        wb_set    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (!f3_legal(req_funct3)) begin
                        flt_set   = 1'b1;
                        flt_cause = CAUSE_ILLEGAL;
                    end else if (f3_misaligned(req_funct3, req_addr[1:0])) begin
                        flt_set   = 1'b1;
                        flt_cause = CAUSE_MISALIGN;
                    end else begin
                        accept_ok = 1'b1;
                        state_d   = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                end else if (timed_out) begin
                    flt_set   = 1'b1;
                    flt_cause = CAUSE_TIMEOUT;
                    state_d   = IDLE;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    if (mem_rerr) begin
                        flt_set   = 1'b1;
                        flt_cause = CAUSE_BUS_ERR;
                        state_d   = IDLE;
                    end else begin
                        wb_set  = 1'b1;
                        state_d = WB;
                    end
                end else if (timed_out) begin
                    flt_set   = 1'b1;
                    flt_cause = CAUSE_TIMEOUT;
                    state_d   = IDLE;
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered datapath and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3_q           <= '0;
            addr_q         <= '0;
            rd_q           <= '0;
            cnt_q          <= '0;
            mem_req_valid  <= 1'b0;
            mem_addr       <= '0;
            RegWrite       <= 1'b0;
            write_register <= '0;
            write_data     <= '0;
            fault          <= 1'b0;
            fault_cause    <= '0;
            fault_addr     <= '0;
        end else begin
            fault    <= flt_set;
            RegWrite <= wb_set && (rd_q != 5'd0);
            if (accept) begin
                f3_q   <= req_funct3;
                addr_q <= req_addr;
                rd_q   <= req_rd;
            end
            if (flt_set) begin
                fault_cause <= flt_cause;
                // Check faults are raised in the accept cycle, before addr_q is loaded
                fault_addr  <= (state_q == IDLE) ? req_addr : addr_q;
            end
            if (accept_ok) begin
                mem_req_valid <= 1'b1;
                mem_addr      <= {req_addr[31:2], 2'b00};
            end else if ((state_q == REQ) && (mem_req_ready || timed_out)) begin
                mem_req_valid <= 1'b0;
            end
            if (accept_ok)
                cnt_q <= '0;
            else if ((state_q == REQ) || (state_q == WAIT))
                cnt_q <= cnt_q + 8'd1;
            if (wb_set) begin
                write_register <= rd_q;
                write_data     <= ext_data;
            end
        end
    end

endmodule
